// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-pass shift sequencer.
package shift_pkg;

  localparam int N_DEF     = 16;
  localparam int AMT_W_DEF = 6;
  localparam int MAX_STEP  = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_sequencer.sv
// Breaks a long logical shift into passes of at most MAX_STEP bits through an
// external combinational barrel shifter, then presents the result.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N-1:0]     req_data,
  input  logic [AMT_W-1:0] req_amount,
  input  logic             req_dir,
  output logic [N-1:0]     sh_in,
  output logic [3:0]       sh_amount,
  output logic             sh_select,
  input  logic [N-1:0]     sh_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_data,
  output logic [2:0]       rsp_passes
);

  state_e           state_q, state_d;
  logic [N-1:0]     work_q, work_d;
  logic [AMT_W-1:0] remain_q, remain_d;
  logic             dir_q, dir_d;
  logic [2:0]       passes_q, passes_d;

  logic [3:0]       chunk;
  logic [AMT_W-1:0] remain_left;

  // Chunk never exceeds remain, so the subtraction cannot wrap.
  always_comb begin
    chunk       = (remain_q > AMT_W'(MAX_STEP)) ? 4'(MAX_STEP) : 4'(remain_q);
    remain_left = remain_q - AMT_W'(chunk);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      remain_q <= '0;
      dir_q    <= 1'b1;
      passes_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      remain_q <= remain_d;
      dir_q    <= dir_d;
      passes_q <= passes_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    remain_d = remain_q;
    dir_d    = dir_q;
    passes_d = passes_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          work_d   = req_data;
          remain_d = req_amount;
          dir_d    = req_dir;
          passes_d = '0;
          state_d  = (req_amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d   = sh_out;
        remain_d = remain_left;
        passes_d = passes_q + 3'd1;
        if (remain_left == '0) state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode from registered state only.
  always_comb begin
    req_ready  = (state_q == IDLE);
    rsp_valid  = (state_q == DONE);
    rsp_data   = (state_q == DONE) ? work_q : '0;
    rsp_passes = (state_q == DONE) ? passes_q : '0;
    sh_in      = work_q;
    sh_select  = dir_q;
    sh_amount  = (state_q == SHIFT) ? chunk : 4'd0;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter N, default 16, SHALL set the data width; it SHALL match the width of the downstream barrel shifter.
REQ-002 Parameter AMT_W, default 6, SHALL set the width of the requested total shift amount (0..63).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  sequencer can accept a request.
REQ-008 req_data  in  N  operand to shift.
REQ-009 req_amount  in  AMT_W  total shift distance.
REQ-010 req_dir  in  1  1 = logical right, 0 = logical left; same encoding as the shifter's select.
REQ-011 sh_in  out  N  operand driven to the combinational shifter.
REQ-012 sh_amount  out  4  per-pass distance driven to the shifter.
REQ-013 sh_select  out  1  direction driven to the shifter.
REQ-014 sh_out  in  N  shifter result for the current pass.
REQ-015 rsp_valid  out  1  result available.
REQ-016 rsp_ready  in  1  consumer accepts result.
REQ-017 rsp_data  out  N  final shifted operand.
REQ-018 rsp_passes  out  3  number of shifter passes used.

Function
REQ-019 FSM states SHALL be IDLE, SHIFT and DONE; all outputs SHALL be decoded from registered state.
REQ-020 req_ready SHALL be 1 only in IDLE; one request at a time, no overlap.
REQ-021 Accept = req_valid & req_ready at a rising edge; this SHALL load work=req_data, remain=req_amount, dir=req_dir and passes=0.
REQ-022 On accept with req_amount==0, next state SHALL be DONE; otherwise it SHALL be SHIFT.
REQ-023 In SHIFT: chunk=min(remain,15); sh_in=work; sh_amount=chunk; sh_select=dir.
REQ-024 Each SHIFT cycle SHALL update work<=sh_out, remain<=remain-chunk and passes<=passes+1.
REQ-025 When remain-chunk==0, SHIFT SHALL transition to DONE; otherwise it SHALL stay in SHIFT.
REQ-026 Latency: for accept at edge t with amount k, rsp_valid SHALL rise in the cycle after edge t+ceil(k/15); for k=0, in the cycle after edge t.
REQ-027 Amounts >=N SHALL be iterated normally and yield 0; no early-out.
REQ-028 Outside SHIFT: sh_amount=0; sh_select=dir; sh_in=work.
REQ-029 In DONE: rsp_valid=1; rsp_data=work and rsp_passes=passes, both held stable.
REQ-030 DONE SHALL wait for rsp_ready, then return to IDLE on that edge; rsp_ready outside DONE SHALL be ignored.
REQ-031 req_valid outside IDLE SHALL be ignored; requests are not queued.
REQ-032 remain arithmetic SHALL be unsigned AMT_W bits and SHALL never underflow; chunk is at most 4 bits.

Reset
REQ-033 rst_n low SHALL force, immediately: state=IDLE, work=0, remain=0, dir=1, passes=0.
REQ-034 During and after reset: req_ready=1, rsp_valid=0, rsp_data=0, rsp_passes=0, sh_in=0, sh_amount=0, sh_select=1.
REQ-035 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation; no rsp_valid SHALL follow.

Structure
REQ-036 Package shift_pkg SHALL hold the state enum (IDLE, SHIFT, DONE), MAX_STEP=15 and the default N/AMT_W constants.
REQ-037 The shifter SHALL stay outside this module and connect via sh_*; no sub-module is instantiated; chunk logic SHALL be inline.

Verification
REQ-038 0x8001, right, amount 1 -> one SHIFT cycle, sh_amount=1; rsp_data=0x4000, rsp_passes=1.
REQ-039 0xABCD, amount 0 -> rsp_valid in the cycle after accept; rsp_data=0xABCD, rsp_passes=0, sh_amount stays 0.
REQ-040 0x00F0, left, amount 63 -> sh_amount sequence 15,15,15,15,3; rsp_data=0x0000, rsp_passes=5.
REQ-041 0x1234, left, amount 4 with rsp_ready low for 3 cycles -> rsp_data=0x2340 held stable; req_ready=0 until the handshake; new req_valid ignored.
REQ-042 0xFFFF, right, amount 30 with rst_n pulsed low during the second pass -> all outputs at reset values immediately; no rsp_valid; req_ready=1 after release.
REQ-043 Back-to-back: 0x0003 right 1, then 0x0003 left 17 -> 0x0001 (passes 1), then 0x0000 (passes 2); each accept occurs only when req_ready=1.
